// File: rtl/csr_pkg.sv
// Shared CSR definitions for the counter unit and the decoder: addresses, op encoding,
// mcountinhibit bit positions and the Zicsr read/modify/write helpers.
package csr_pkg;

  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

  typedef enum logic [1:0] {CSR_NONE, CSR_RW, CSR_RS, CSR_RC} csr_op_t;

  localparam int INH_CY = 0;
  localparam int INH_IR = 2;

  // RS/RC with a zero operand are pure reads and must not count as writes.
  function automatic logic csr_wr_intent(csr_op_t op, logic [31:0] wdata);
    return (op == CSR_RW) || (((op == CSR_RS) || (op == CSR_RC)) && (wdata != 32'd0));
  endfunction

  function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old_val, logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/counter64.sv
// 64-bit counter with independent 32-bit half writes; a write on an edge replaces
// the increment for that edge, so a low-half write never carries into the high half.
module counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  input  logic [63:0] rst_val,
  output logic [63:0] count
);

  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (wr_lo) begin
      count_d[31:0] = wdata;
    end else if (wr_hi) begin
      count_d[63:32] = wdata;
    end else if (inc) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= rst_val;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/csr_counter_unit.sv
// cycle/instret counters with Zicsr access and illegal-access detection.
// Define CSR_INHIBIT_EN to add mcountinhibit (0x320, bits CY and IR).
module csr_counter_unit
  import csr_pkg::*;
#(
  parameter int          CNT_W         = 64,
  parameter logic [63:0] RESET_CYCLE   = 64'd0,
  parameter logic [63:0] RESET_INSTRET = 64'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             retire,
  input  logic             csr_valid,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [31:0]      csr_wdata,
  output logic [CNT_W-1:0] cycle_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [31:0]      csr_rdata,
  output logic             csr_illegal
);

  csr_op_t     op;
  logic [31:0] old_val, new_val;
  logic        supported, read_only, wr_intent, commit;
  logic        sel_cyc_lo, sel_cyc_hi, sel_ins_lo, sel_ins_hi;
  logic        cy_run, ir_run;
  logic [63:0] cycle_cnt, instret_cnt;

`ifdef CSR_INHIBIT_EN
  logic        sel_inh;
  logic        inh_cy_q, inh_cy_d, inh_ir_q, inh_ir_d;
  logic [31:0] inh_val;

  always_comb begin
    inh_val         = 32'd0;
    inh_val[INH_CY] = inh_cy_q;
    inh_val[INH_IR] = inh_ir_q;
  end
`endif

  assign op = csr_op_t'(csr_op);

  always_comb begin
    old_val    = 32'd0;
    supported  = 1'b0;
    read_only  = 1'b0;
    sel_cyc_lo = 1'b0;
    sel_cyc_hi = 1'b0;
    sel_ins_lo = 1'b0;
    sel_ins_hi = 1'b0;
`ifdef CSR_INHIBIT_EN
    sel_inh    = 1'b0;
`endif
    case (csr_addr)
      CSR_CYCLE:     begin supported = 1'b1; read_only = 1'b1; old_val = cycle_cnt[31:0];    end
      CSR_CYCLEH:    begin supported = 1'b1; read_only = 1'b1; old_val = cycle_cnt[63:32];   end
      CSR_INSTRET:   begin supported = 1'b1; read_only = 1'b1; old_val = instret_cnt[31:0];  end
      CSR_INSTRETH:  begin supported = 1'b1; read_only = 1'b1; old_val = instret_cnt[63:32]; end
      CSR_MCYCLE:    begin supported = 1'b1; sel_cyc_lo = 1'b1; old_val = cycle_cnt[31:0];    end
      CSR_MCYCLEH:   begin supported = 1'b1; sel_cyc_hi = 1'b1; old_val = cycle_cnt[63:32];   end
      CSR_MINSTRET:  begin supported = 1'b1; sel_ins_lo = 1'b1; old_val = instret_cnt[31:0];  end
      CSR_MINSTRETH: begin supported = 1'b1; sel_ins_hi = 1'b1; old_val = instret_cnt[63:32]; end
`ifdef CSR_INHIBIT_EN
      CSR_MCOUNTINHIBIT: begin supported = 1'b1; sel_inh = 1'b1; old_val = inh_val; end
`endif
      default: ;
    endcase
  end

  assign wr_intent   = csr_wr_intent(op, csr_wdata);
  assign csr_illegal = csr_valid && (!supported || (wr_intent && read_only));
  assign commit      = csr_valid && !csr_illegal && !stall && wr_intent;
  assign new_val     = csr_apply(op, old_val, csr_wdata);
  assign csr_rdata   = (csr_valid && !csr_illegal) ? old_val : 32'd0;

`ifdef CSR_INHIBIT_EN
  // The registered inhibit bits gate the increment, so a new setting applies from the next edge.
  always_comb begin
    inh_cy_d = inh_cy_q;
    inh_ir_d = inh_ir_q;
    if (commit && sel_inh) begin
      inh_cy_d = new_val[INH_CY];
      inh_ir_d = new_val[INH_IR];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_cy_q <= 1'b0;
      inh_ir_q <= 1'b0;
    end else begin
      inh_cy_q <= inh_cy_d;
      inh_ir_q <= inh_ir_d;
    end
  end

  assign cy_run = !inh_cy_q;
  assign ir_run = retire && !stall && !inh_ir_q;
`else
  assign cy_run = 1'b1;
  assign ir_run = retire && !stall;
`endif

  counter64 u_cycle (
    .clk     (clk),
    .rst     (rst),
    .inc     (cy_run),
    .wr_lo   (commit && sel_cyc_lo),
    .wr_hi   (commit && sel_cyc_hi),
    .wdata   (new_val),
    .rst_val (RESET_CYCLE),
    .count   (cycle_cnt)
  );

  counter64 u_instret (
    .clk     (clk),
    .rst     (rst),
    .inc     (ir_run),
    .wr_lo   (commit && sel_ins_lo),
    .wr_hi   (commit && sel_ins_hi),
    .wdata   (new_val),
    .rst_val (RESET_INSTRET),
    .count   (instret_cnt)
  );

  assign cycle_o   = cycle_cnt;
  assign instret_o = instret_cnt;

endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed bench for csr_counter_unit: counting, CSR read/modify/write, illegal
// accesses, stall, wrap-around and (with CSR_INHIBIT_EN) mcountinhibit.
module tb_csr_counter_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        retire;
  logic        csr_valid;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [63:0] cycle_o;
  logic [63:0] instret_o;
  logic [31:0] csr_rdata;
  logic        csr_illegal;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_cyc;
  logic [63:0] saved;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  csr_counter_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .retire      (retire),
    .csr_valid   (csr_valid),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .cycle_o     (cycle_o),
    .instret_o   (instret_o),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // One clock edge; the expected cycle count advances unless the caller overrides it.
  task automatic step();
    @(posedge clk);
    #1;
    exp_cyc = exp_cyc + 64'd1;
  endtask

  task automatic csr(input logic v, input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_valid = v;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = d;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; retire = 1'b0;
    csr_valid = 1'b0; csr_op = OP_NONE; csr_addr = 12'h000; csr_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_cycle", cycle_o, 64'd0);
    check_eq("reset_instret", instret_o, 64'd0);
    check_eq("reset_illegal", {63'd0, csr_illegal}, 64'd0);
    rst = 1'b0;
    exp_cyc = 64'd0;

    repeat (10) step();
    check_eq("count10_cycle", cycle_o, exp_cyc);
    check_eq("count10_instret", instret_o, 64'd0);
    csr(1'b1, OP_RS, 12'hC00, 32'd0);
    check_eq("read_c00", {32'd0, csr_rdata}, 64'd10);
    check_eq("read_c00_legal", {63'd0, csr_illegal}, 64'd0);

    // Low-half write then high-half write: no increment on write edges, then carry.
    csr(1'b1, OP_RW, 12'hB00, 32'hFFFF_FFFF);
    check_eq("rw_b00_rdata_old", {32'd0, csr_rdata}, 64'd10);
    step(); exp_cyc = 64'h0000_0000_FFFF_FFFF;
    check_eq("rw_b00_cycle", cycle_o, exp_cyc);
    csr(1'b1, OP_RW, 12'hB80, 32'd0);
    check_eq("rw_b80_rdata_old", {32'd0, csr_rdata}, 64'd0);
    step(); exp_cyc = 64'h0000_0000_FFFF_FFFF;
    check_eq("rw_b80_cycle_hold", cycle_o, exp_cyc);
    csr(1'b0, OP_NONE, 12'h000, 32'd0);
    step();
    check_eq("carry_into_hi", cycle_o, 64'h0000_0001_0000_0000);

    // minstret write wins over a same-edge retire.
    retire = 1'b1;
    csr(1'b1, OP_RW, 12'hB02, 32'd5);
    step();
    check_eq("minstret_write_drops_retire", instret_o, 64'd5);
    csr(1'b0, OP_NONE, 12'h000, 32'd0);
    step();
    check_eq("retire_after_write", instret_o, 64'd6);
    retire = 1'b0;

    // Illegal accesses.
    csr(1'b1, OP_RW, 12'hC00, 32'd7);
    check_eq("rw_c00_illegal", {63'd0, csr_illegal}, 64'd1);
    check_eq("rw_c00_rdata", {32'd0, csr_rdata}, 64'd0);
    step();
    check_eq("rw_c00_no_effect", cycle_o, exp_cyc);
    csr(1'b1, OP_RS, 12'hC00, 32'd0);
    check_eq("rs0_c00_legal", {63'd0, csr_illegal}, 64'd0);
    check_eq("rs0_c00_rdata", {32'd0, csr_rdata}, {32'd0, exp_cyc[31:0]});
    csr(1'b1, OP_RS, 12'hC00, 32'd1);
    check_eq("rs1_c00_illegal", {63'd0, csr_illegal}, 64'd1);
    csr(1'b1, OP_NONE, 12'h7C0, 32'd0);
    check_eq("addr_7c0_illegal", {63'd0, csr_illegal}, 64'd1);
    check_eq("addr_7c0_rdata", {32'd0, csr_rdata}, 64'd0);
    csr(1'b1, OP_RC, 12'hC02, 32'd0);
    check_eq("rc0_c02_rdata", {32'd0, csr_rdata}, 64'd6);
    csr(1'b0, OP_RW, 12'hB00, 32'h123);
    check_eq("invalid_rdata_zero", {32'd0, csr_rdata}, 64'd0);
    step();
    check_eq("invalid_no_write", cycle_o, exp_cyc);

    // Stalled write with retire: nothing happens to instret until the stall lifts.
    stall = 1'b1; retire = 1'b1;
    csr(1'b1, OP_RW, 12'hB02, 32'd9);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_instret_hold", instret_o, 64'd6);
    end
    check_eq("stall_cycle_runs", cycle_o, exp_cyc);
    stall = 1'b0;
    step();
    check_eq("stall_release_commit", instret_o, 64'd9);
    retire = 1'b0;

    csr(1'b1, OP_RS, 12'hB02, 32'd2);
    check_eq("rs_b02_rdata", {32'd0, csr_rdata}, 64'd9);
    step();
    check_eq("rs_b02_result", instret_o, 64'd11);
    csr(1'b1, OP_RC, 12'hB02, 32'd1);
    check_eq("rc_b02_rdata", {32'd0, csr_rdata}, 64'd11);
    step();
    check_eq("rc_b02_result", instret_o, 64'd10);

    // Full 64-bit wrap on both counters.
    csr(1'b1, OP_RW, 12'hB80, 32'hFFFF_FFFF);
    saved = exp_cyc;
    step(); exp_cyc = {32'hFFFF_FFFF, saved[31:0]};
    check_eq("wrap_hi_written", cycle_o, exp_cyc);
    csr(1'b1, OP_RW, 12'hB00, 32'hFFFF_FFFF);
    step(); exp_cyc = 64'hFFFF_FFFF_FFFF_FFFF;
    check_eq("wrap_all_ones", cycle_o, exp_cyc);
    csr(1'b1, OP_RW, 12'hB82, 32'hFFFF_FFFF);
    step();
    csr(1'b1, OP_RW, 12'hB02, 32'hFFFF_FFFF);
    step();
    check_eq("instret_all_ones", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("cycle_wrapped", cycle_o, exp_cyc);
    csr(1'b0, OP_NONE, 12'h000, 32'd0);
    retire = 1'b1;
    step();
    retire = 1'b0;
    check_eq("instret_wrapped", instret_o, 64'd0);
    check_eq("cycle_after_wrap", cycle_o, exp_cyc);

`ifdef CSR_INHIBIT_EN
    csr(1'b1, OP_RW, 12'h320, 32'h5);
    check_eq("inh_write_legal", {63'd0, csr_illegal}, 64'd0);
    step();
    check_eq("inh_write_edge_counts", cycle_o, exp_cyc);
    csr(1'b0, OP_NONE, 12'h000, 32'd0);
    retire = 1'b1;
    saved = exp_cyc;
    step(); step(); exp_cyc = saved;
    retire = 1'b0;
    check_eq("inh_cycle_frozen", cycle_o, exp_cyc);
    check_eq("inh_instret_frozen", instret_o, 64'd0);
    csr(1'b1, OP_RS, 12'h320, 32'd0);
    check_eq("inh_read_5", {32'd0, csr_rdata}, 64'd5);
    csr(1'b1, OP_RW, 12'h320, 32'hFFFF_FFFF);
    step(); exp_cyc = saved;
    csr(1'b1, OP_RS, 12'h320, 32'd0);
    check_eq("inh_read_masked", {32'd0, csr_rdata}, 64'd5);
    csr(1'b1, OP_RW, 12'hB00, 32'h55);
    step(); exp_cyc = {saved[63:32], 32'h55};
    check_eq("inh_explicit_write", cycle_o, exp_cyc);
    csr(1'b1, OP_RW, 12'h320, 32'd0);
    step(); exp_cyc = {saved[63:32], 32'h55};
    check_eq("inh_clear_edge_frozen", cycle_o, exp_cyc);
    csr(1'b0, OP_NONE, 12'h000, 32'd0);
    step();
    check_eq("inh_cleared_runs", cycle_o, exp_cyc);
`else
    csr(1'b1, OP_NONE, 12'h320, 32'd0);
    check_eq("addr_320_illegal", {63'd0, csr_illegal}, 64'd1);
    check_eq("addr_320_rdata", {32'd0, csr_rdata}, 64'd0);
    csr(1'b1, OP_RW, 12'h320, 32'h5);
    step();
    check_eq("addr_320_no_freeze", cycle_o, exp_cyc);
    csr(1'b0, OP_NONE, 12'h000, 32'd0);
`endif

    // Asynchronous reset takes effect between edges.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("async_reset_cycle", cycle_o, 64'd0);
    check_eq("async_reset_instret", instret_o, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
